// File: rtl/wb_everloop.sv
// wb_everloop: Wishbone slave driving the SK6812 RGBW everloop LED ring.
// LED words sit in a small RAM; a bit-timing FSM serialises them on one line.
module wb_everloop #(
   parameter int clk_freq   = 100000000,
   parameter int num_leds   = 35,
   parameter int t0h_cycles = 30,
   parameter int t1h_cycles = 60,
   parameter int bit_cycles = 125,
   parameter int rst_cycles = 8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   output logic        everloop_ctl,
   output logic        intr
);

   localparam int aw   = (num_leds > 1) ? $clog2(num_leds) : 1;
   localparam int cmax = (rst_cycles > bit_cycles) ? rst_cycles : bit_cycles;
   localparam int cw   = (cmax > 1) ? $clog2(cmax) : 1;

   localparam logic [cw-1:0] t0h_last = cw'(t0h_cycles - 1);
   localparam logic [cw-1:0] t1h_last = cw'(t1h_cycles - 1);
   localparam logic [cw-1:0] bit_last = cw'(bit_cycles - 1);
   localparam logic [cw-1:0] rst_last = cw'(rst_cycles - 1);
   localparam logic [aw-1:0] led_last = aw'(num_leds - 1);
   localparam logic [6:0]    nleds7   = 7'(num_leds);

   typedef enum logic [2:0] {IDLE, FETCH, HIGH, LOW, LATCH} state_t;

   if (num_leds < 1 || num_leds > 64 || clk_freq < 1 ||
       t0h_cycles < 1 || t1h_cycles >= bit_cycles) begin : g_bad_params
      $error("wb_everloop: illegal parameter set");
   end

   state_t        state_q, state_d;
   logic [cw-1:0] cnt_q;
   logic [4:0]    bit_q;
   logic [aw-1:0] led_q;
   logic [31:0]   shift_q, next_q;
   logic          auto_q, pending_q;
   logic [31:0]   mem [0:(1<<aw)-1];
   logic [31:0]   rdata;
   logic [5:0]    wb_n;
   logic [aw-1:0] wb_idx;
   logic          led_hit, acc, wr, ctrl_wr, start_wr, busy;
   logic          high_end, bit_end, latch_end, word_end, frame_end;
   logic          unused_adr;

   assign wb_n      = wb_adr_i[7:2];
   assign wb_idx    = wb_n[aw-1:0];
   assign led_hit   = wb_adr_i[8] && ({1'b0, wb_n} < nleds7);
   assign acc       = wb_stb_i & wb_cyc_i & ~wb_ack_o;
   assign wr        = acc & wb_we_i;
   assign ctrl_wr   = wr & ~wb_adr_i[8] & (wb_n == 6'd0) & wb_sel_i[0];
   assign start_wr  = ctrl_wr & wb_dat_i[0];
   assign busy      = (state_q != IDLE);
   assign unused_adr = ^{wb_adr_i[31:9], wb_adr_i[1:0]};

   assign high_end  = (cnt_q == (shift_q[31] ? t1h_last : t0h_last));
   assign bit_end   = (cnt_q == bit_last);
   assign latch_end = (cnt_q == rst_last);
   assign word_end  = (bit_q == 5'd31);
   assign frame_end = word_end && (led_q == led_last);

   // LED RAM write port, byte-masked, committed on the ack edge
   always_ff @(posedge clk) begin
      if (wr && led_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) mem[wb_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   // Register/RAM read mux for the bus
   always_comb begin
      rdata = '0;
      if (wb_adr_i[8]) begin
         if (led_hit) rdata = mem[wb_idx];
      end else begin
         case (wb_n)
            6'd0:    rdata = {30'd0, auto_q, 1'b0};
            6'd1:    rdata = {30'd0, pending_q, busy};
            6'd2:    rdata = 32'(num_leds);
            default: rdata = '0;
         endcase
      end
   end

   // Bus handshake, CTRL and the pending-start flag
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_ack_o  <= 1'b0;
         wb_dat_o  <= '0;
         auto_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
         wb_dat_o <= (acc && !wb_we_i) ? rdata : '0;
         if (ctrl_wr) auto_q <= wb_dat_i[1];
         if (start_wr && busy) pending_q <= 1'b1;
         else if (state_d == FETCH) pending_q <= 1'b0;
      end
   end

   // Next-state logic for the bit-timing FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_wr || pending_q) state_d = FETCH;
         FETCH: state_d = HIGH;
         HIGH:  if (high_end) state_d = LOW;
         LOW:   if (bit_end) state_d = frame_end ? LATCH : HIGH;
         LATCH: if (latch_end) state_d = (auto_q || pending_q) ? FETCH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register plus registered line and frame-done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         everloop_ctl <= 1'b0;
         intr         <= 1'b0;
      end else begin
         state_q      <= state_d;
         everloop_ctl <= (state_d == HIGH);
         intr         <= (state_q == LATCH) && latch_end;
      end
   end

   // Cycle/bit/LED counters, shift register and next-word prefetch
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         bit_q   <= '0;
         led_q   <= '0;
         shift_q <= '0;
         next_q  <= '0;
      end else begin
         unique case (state_q)
            FETCH: begin
               shift_q <= mem[0];
               cnt_q   <= '0;
               bit_q   <= '0;
               led_q   <= '0;
            end
            HIGH: begin
               cnt_q <= cnt_q + cw'(1);
               if (word_end && cnt_q == '0 && led_q != led_last)
                  next_q <= mem[led_q + aw'(1)];
            end
            LOW: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (!word_end) begin
                     bit_q   <= bit_q + 5'd1;
                     shift_q <= shift_q << 1;
                  end else if (led_q != led_last) begin
                     bit_q   <= '0;
                     led_q   <= led_q + aw'(1);
                     shift_q <= next_q;
                  end
               end else begin
                  cnt_q <= cnt_q + cw'(1);
               end
            end
            LATCH:   cnt_q <= latch_end ? '0 : cnt_q + cw'(1);
            default: cnt_q <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_everloop.sv
// tb_wb_everloop: directed bench for the everloop Wishbone LED driver.
// Three instances: 35 LEDs, 2 LEDs real timing, 2 LEDs shortened timing.
module tb_wb_everloop;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] adr, wdat;
   logic [3:0]  sel;
   logic        stb, we;
   logic        cyc  [3];
   logic [31:0] rdat [3];
   logic        ack  [3];
   logic        ctl  [3];
   logic        intr [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_everloop u35 (
      .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(wdat),
      .wb_dat_o(rdat[0]), .wb_sel_i(sel), .wb_stb_i(stb),
      .wb_cyc_i(cyc[0]), .wb_we_i(we), .wb_ack_o(ack[0]),
      .everloop_ctl(ctl[0]), .intr(intr[0]));

   wb_everloop #(.num_leds(2)) u2 (
      .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(wdat),
      .wb_dat_o(rdat[1]), .wb_sel_i(sel), .wb_stb_i(stb),
      .wb_cyc_i(cyc[1]), .wb_we_i(we), .wb_ack_o(ack[1]),
      .everloop_ctl(ctl[1]), .intr(intr[1]));

   wb_everloop #(.num_leds(2), .t0h_cycles(2), .t1h_cycles(5),
                 .bit_cycles(10), .rst_cycles(20)) uf (
      .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(wdat),
      .wb_dat_o(rdat[2]), .wb_sel_i(sel), .wb_stb_i(stb),
      .wb_cyc_i(cyc[2]), .wb_we_i(we), .wb_ack_o(ack[2]),
      .everloop_ctl(ctl[2]), .intr(intr[2]));

   localparam int FAST_FRAME = 1 + 2*32*10 + 20;

   int cyc_n = 0;
   int n_intr [3] = '{0, 0, 0};
   int intr_q [$];

   // passive intr monitor
   always @(negedge clk) begin
      cyc_n = cyc_n + 1;
      for (int i = 0; i < 3; i++)
         if (intr[i] === 1'b1) n_intr[i] = n_intr[i] + 1;
      if (intr[2] === 1'b1) intr_q.push_back(cyc_n);
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] e;
   } vec_t;

   vec_t vq [$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] e);
      vec_t v;
      v.w = w; v.a = a; v.d = d; v.s = s; v.e = e;
      vq.push_back(v);
   endtask

   task automatic bus(input int i, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] q);
      @(negedge clk);
      adr = a; wdat = d; sel = s; we = w; stb = 1'b1; cyc[i] = 1'b1;
      @(negedge clk);
      chk("ack_latency", {31'd0, ack[i]}, 32'd1);
      q = rdat[i];
      stb = 1'b0; we = 1'b0; cyc[i] = 1'b0;
   endtask

   task automatic wait_q(input int target, input int limit);
      int n = 0;
      while (intr_q.size() < target && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   function automatic int gap(input int k);
      if (k >= 1 && intr_q.size() > k) return intr_q[k] - intr_q[k-1];
      return -1;
   endfunction

   logic [31:0] q, qb;
   logic [31:0] w0, w1, word;
   int          hi_cnt [64];
   int          shape_err, latch_hi, intr_k, intr_n;
   int          bi, ph, hl, base, base0;

   initial begin
      reset = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
      for (int i = 0; i < 3; i++) cyc[i] = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_flags%0d", i),
             {29'd0, ack[i], ctl[i], intr[i]}, 32'd0);
         chk($sformatf("rst_dat%0d", i), rdat[i], 32'd0);
      end

      // strobe held for two clocks: ack must be a single-cycle pulse
      @(negedge clk);
      adr = 32'h4; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc[0] = 1'b1;
      @(negedge clk);
      chk("ack_rise", {31'd0, ack[0]}, 32'd1);
      chk("status_rst", rdat[0], 32'd0);
      @(negedge clk);
      chk("ack_one_cycle", {31'd0, ack[0]}, 32'd0);
      stb = 1'b0; cyc[0] = 1'b0;

      // register / RAM vectors on the 35-LED instance
      add(0, 32'h004, 32'h0,        4'hF, 32'h0);
      add(0, 32'h008, 32'h0,        4'hF, 32'd35);
      add(0, 32'h000, 32'h0,        4'hF, 32'h0);
      add(1, 32'h100, 32'h0,        4'hF, 32'h0);
      add(1, 32'h100, 32'hA5000000, 4'h8, 32'h0);
      add(0, 32'h100, 32'h0,        4'hF, 32'hA5000000);
      add(1, 32'h100, 32'h000000FF, 4'h1, 32'h0);
      add(0, 32'h100, 32'h0,        4'hF, 32'hA50000FF);
      add(1, 32'h1A0, 32'h12345678, 4'hF, 32'h0);
      add(0, 32'h1A0, 32'h0,        4'hF, 32'h0);
      add(1, 32'h188, 32'hDEADBEEF, 4'hF, 32'h0);
      add(0, 32'h188, 32'h0,        4'hF, 32'hDEADBEEF);
      add(1, 32'h18C, 32'h55AA55AA, 4'hF, 32'h0);
      add(0, 32'h18C, 32'h0,        4'hF, 32'h0);
      add(1, 32'h104, 32'hFFFFFFFF, 4'hF, 32'h0);
      add(1, 32'h104, 32'h0,        4'h6, 32'h0);
      add(0, 32'h104, 32'h0,        4'hF, 32'hFF0000FF);
      add(1, 32'h004, 32'hFFFFFFFF, 4'hF, 32'h0);
      add(0, 32'h004, 32'h0,        4'hF, 32'h0);
      add(0, 32'h00C, 32'h0,        4'hF, 32'h0);
      add(1, 32'h000, 32'h2,        4'h1, 32'h0);
      add(0, 32'h000, 32'h0,        4'hF, 32'h2);
      add(1, 32'h000, 32'h0,        4'h1, 32'h0);
      add(0, 32'h000, 32'h0,        4'hF, 32'h0);
      for (int i = 0; i < vq.size(); i++) begin
         bus(0, vq[i].w, vq[i].a, vq[i].d, vq[i].s, q);
         if (!vq[i].w) chk($sformatf("vec%0d", i), q, vq[i].e);
      end

      // full-timing waveform on the 2-LED instance
      w0 = 32'h80000001;
      w1 = 32'h00000000;
      bus(1, 1, 32'h100, w0, 4'hF, q);
      bus(1, 1, 32'h104, w1, 4'hF, q);
      for (int b = 0; b < 64; b++) hi_cnt[b] = 0;
      shape_err = 0; latch_hi = 0; intr_k = 0; intr_n = 0;
      bus(1, 1, 32'h000, 32'h1, 4'h1, q);
      fork
         begin
            for (int k = 1; k <= 16002; k++) begin
               @(negedge clk);
               if (k <= 8000) begin
                  bi = (k - 1) / 125;
                  ph = (k - 1) % 125;
                  word = (bi < 32) ? w0 : w1;
                  hl = word[31 - (bi % 32)] ? 60 : 30;
                  if (ctl[1] === 1'b1) hi_cnt[bi]++;
                  if (ctl[1] !== (ph < hl)) shape_err++;
               end else if (ctl[1] !== 1'b0) begin
                  latch_hi++;
               end
               if (intr[1] === 1'b1) begin
                  intr_n++;
                  if (intr_k == 0) intr_k = k;
               end
            end
         end
         begin
            repeat (98) @(negedge clk);
            bus(1, 0, 32'h004, 32'h0, 4'hF, qb);
            chk("busy_mid", qb, 32'h1);
            repeat (15998 - 100) @(negedge clk);
            bus(1, 0, 32'h004, 32'h0, 4'hF, qb);
            chk("busy_latch", qb, 32'h1);
            bus(1, 0, 32'h004, 32'h0, 4'hF, qb);
            chk("busy_after_intr", qb, 32'h0);
         end
      join
      for (int b = 0; b < 64; b++) begin
         word = (b < 32) ? w0 : w1;
         hl = word[31 - (b % 32)] ? 60 : 30;
         chk($sformatf("bit%0d_high", b), hi_cnt[b], hl);
      end
      chk("wave_shape", shape_err, 0);
      chk("latch_low", latch_hi, 0);
      chk("intr_cycle", intr_k, 16001);
      chk("intr_pulses", intr_n, 1);

      // START during a frame: pending, then one extra frame back-to-back
      bus(2, 1, 32'h100, 32'hF0F0F0F0, 4'hF, q);
      bus(2, 1, 32'h104, 32'h0F0F0F0F, 4'hF, q);
      base = intr_q.size();
      bus(2, 1, 32'h000, 32'h1, 4'h1, q);
      repeat (50) @(negedge clk);
      bus(2, 0, 32'h004, 32'h0, 4'hF, q);
      chk("pend_before", q, 32'h1);
      bus(2, 1, 32'h000, 32'h1, 4'h1, q);
      bus(2, 1, 32'h000, 32'h1, 4'h1, q);
      bus(2, 0, 32'h004, 32'h0, 4'hF, q);
      chk("pend_status", q, 32'h3);
      wait_q(base + 2, 3000);
      repeat (800) @(negedge clk);
      chk("pend_count", intr_q.size() - base, 2);
      chk("pend_gap", gap(base + 1), FAST_FRAME);
      bus(2, 0, 32'h004, 32'h0, 4'hF, q);
      chk("pend_idle", q, 32'h0);

      // AUTO: continuous frames; clearing mid-frame finishes that frame
      base = intr_q.size();
      bus(2, 1, 32'h000, 32'h3, 4'h1, q);
      wait_q(base + 3, 3000);
      bus(2, 0, 32'h000, 32'h0, 4'hF, q);
      chk("auto_ctrl", q, 32'h2);
      repeat (100) @(negedge clk);
      bus(2, 1, 32'h000, 32'h0, 4'h1, q);
      wait_q(base + 4, 1500);
      repeat (1500) @(negedge clk);
      chk("auto_count", intr_q.size() - base, 4);
      chk("auto_gap1", gap(base + 1), FAST_FRAME);
      chk("auto_gap2", gap(base + 2), FAST_FRAME);
      chk("auto_gap3", gap(base + 3), FAST_FRAME);
      bus(2, 0, 32'h004, 32'h0, 4'hF, q);
      chk("auto_idle", q, 32'h0);

      // reset during HIGH of LED 5 on the 35-LED instance
      for (int i = 0; i < 5; i++)
         bus(0, 1, 32'h100 + 4*i, 32'h01010101 * (i + 1), 4'hF, q);
      bus(0, 1, 32'h114, 32'hFFFFFFFF, 4'hF, q);
      base0 = n_intr[0];
      bus(0, 1, 32'h000, 32'h1, 4'h1, q);
      repeat (20002) @(negedge clk);
      chk("led5_high", {31'd0, ctl[0]}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("ctl_after_reset", {31'd0, ctl[0]}, 32'd0);
      reset = 1'b0;
      bus(0, 0, 32'h004, 32'h0, 4'hF, q);
      chk("busy_after_reset", q, 32'h0);
      repeat (50) @(negedge clk);
      chk("no_intr_abort", n_intr[0] - base0, 0);
      bus(0, 0, 32'h114, 32'h0, 4'hF, q);
      chk("ram_led5", q, 32'hFFFFFFFF);
      bus(0, 0, 32'h108, 32'h0, 4'hF, q);
      chk("ram_led2", q, 32'h03030303);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
